music_timer_bcd: RTL and testbench

- Parametrised successor of the single-digit-minute playback timer; shows elapsed or remaining track time as BCD digits mm..m:ss.
- One synchronous clock domain. Internal prescaler generates the 1 s tick, replacing the rippled digit clocks.
- Adds a configurable minute-digit count, up/down mode, preset load and a done flag.
- Drives the 7-segment display decoders and signals end-of-track to the player control FSM.

---
 rtl/music_timer_bcd_if.sv | 50 +++++
 rtl/music_timer_bcd.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_music_timer_bcd.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/music_timer_bcd_if.sv
// Bus bundle for music_timer_bcd: player-control inputs and the BCD
// display / status outputs. The lap-capture signals exist only when
// the design is built with TIMER_LAP_EN defined.
interface music_timer_bcd_if #(
    parameter int MIN_DIGITS = 2
);
    // Control from the player FSM
    logic                        count;
    logic                        clear;
    logic                        dir;
    logic                        load;
    logic [8+4*MIN_DIGITS-1:0]   load_value;

    // Display and status towards decoders / player FSM
    logic [3:0]                  seconds0;
    logic [3:0]                  seconds1;
    logic [4*MIN_DIGITS-1:0]     minutes;
    logic                        sec_tick;
    logic                        done;

`ifdef TIMER_LAP_EN
    logic                        lap;
    logic [3:0]                  lap_seconds0;
    logic [3:0]                  lap_seconds1;
    logic [4*MIN_DIGITS-1:0]     lap_minutes;
    logic                        lap_valid;

    modport master (
        output count, clear, dir, load, load_value, lap,
        input  seconds0, seconds1, minutes, sec_tick, done,
        input  lap_seconds0, lap_seconds1, lap_minutes, lap_valid
    );

    modport slave (
        input  count, clear, dir, load, load_value, lap,
        output seconds0, seconds1, minutes, sec_tick, done,
        output lap_seconds0, lap_seconds1, lap_minutes, lap_valid
    );
`else
    modport master (
        output count, clear, dir, load, load_value,
        input  seconds0, seconds1, minutes, sec_tick, done
    );

    modport slave (
        input  count, clear, dir, load, load_value,
        output seconds0, seconds1, minutes, sec_tick, done
    );
`endif
endinterface

// File: rtl/music_timer_bcd.sv
// Playback timer showing elapsed (up) or remaining (down) track time as
// BCD mm..m:ss. A prescaler derives the 1 s tick from clk; a small FSM
// (STOPPED / RUNNING / DONE) gates counting and flags end-of-track.
// Optional lap capture registers are built when TIMER_LAP_EN is defined.
module music_timer_bcd #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int MIN_DIGITS    = 2
) (
    input  logic              clk,
    input  logic              reset,
    music_timer_bcd_if.slave  bus
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    typedef logic [MIN_DIGITS-1:0][3:0] min_t;

    state_e         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [3:0]     s0_q, s0_d;
    logic [3:0]     s1_q, s1_d;
    min_t           min_q, min_d;
    logic           sec_tick_q, sec_tick_d;

    // Candidate next values for one second up and one second down
    logic [3:0]     inc_s0, inc_s1, dec_s0, dec_s1;
    min_t           inc_min, dec_min;
    logic           inc_carry, dec_borrow;

    logic           tick;
    logic           at_limit;
    logic           next_is_limit;
    logic           reach_done;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic all_nines(input min_t m);
        all_nines = 1'b1;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (m[i] != 4'd9) all_nines = 1'b0;
        end
    endfunction

    function automatic logic all_zero(input min_t m);
        all_zero = 1'b1;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (m[i] != 4'd0) all_zero = 1'b0;
        end
    endfunction

    function automatic logic [3:0] clamp_nibble(input logic [3:0] n, input logic [3:0] max);
        clamp_nibble = (n > max) ? max : n;
    endfunction

    // ------------------------------------------------------------------
    // Increment / decrement chains
    // ------------------------------------------------------------------

    // Up-count: s0 9->0, s1 5->0, each minute digit 9->0, carry rippling upward
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        inc_s0    = s0_q;
        inc_s1    = s1_q;
        inc_min   = min_q;
        inc_carry = 1'b0;
        if (s0_q == 4'd9) begin
            inc_s0    = 4'd0;
            inc_carry = 1'b1;
        end else begin
            inc_s0 = s0_q + 4'd1;
        end
        if (inc_carry) begin
            if (s1_q == 4'd5) begin
                inc_s1 = 4'd0;
            end else begin
                inc_s1    = s1_q + 4'd1;
                inc_carry = 1'b0;
            end
        end
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (inc_carry) begin
                if (min_q[i] == 4'd9) begin
                    inc_min[i] = 4'd0;
                end else begin
                    inc_min[i] = min_q[i] + 4'd1;
                    inc_carry  = 1'b0;
                end
            end
        end
    end

    // Down-count: s0 0->9, s1 0->5, each minute digit 0->9, borrow rippling upward
    always_comb begin
        dec_s0     = s0_q;
        dec_s1     = s1_q;
        dec_min    = min_q;
        dec_borrow = 1'b0;
        if (s0_q == 4'd0) begin
            dec_s0     = 4'd9;
            dec_borrow = 1'b1;
        end else begin
            dec_s0 = s0_q - 4'd1;
        end
        if (dec_borrow) begin
            if (s1_q == 4'd0) begin
                dec_s1 = 4'd5;
            end else begin
                dec_s1     = s1_q - 4'd1;
                dec_borrow = 1'b0;
            end
        end
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (dec_borrow) begin
                if (min_q[i] == 4'd0) begin
                    dec_min[i] = 4'd9;
                end else begin
                    dec_min[i] = min_q[i] - 4'd1;
                    dec_borrow = 1'b0;
                end
            end
        end
    end

    // Tick and limit detection; a tick already sitting at the limit holds the value
    always_comb begin
        tick = (state_q == ST_RUNNING) && (presc_q == PRESC_LAST);
        if (bus.dir) begin
            at_limit      = (s0_q == 4'd0) && (s1_q == 4'd0) && all_zero(min_q);
            next_is_limit = (dec_s0 == 4'd0) && (dec_s1 == 4'd0) && all_zero(dec_min);
        end else begin
            at_limit      = (s0_q == 4'd9) && (s1_q == 4'd5) && all_nines(min_q);
            next_is_limit = (inc_s0 == 4'd9) && (inc_s1 == 4'd5) && all_nines(inc_min);
        end
        reach_done = tick && (at_limit || next_is_limit);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) state_q <= ST_STOPPED;
        else        state_q <= state_d;
    end

    // Next state: clear/load override everything and restart by count level
    always_comb begin
        state_d = state_q;
        if (bus.clear || bus.load) begin
            state_d = bus.count ? ST_RUNNING : ST_STOPPED;
        end else begin
            case (state_q)
                ST_STOPPED: if (bus.count) state_d = ST_RUNNING;
                ST_RUNNING: begin
                    if (reach_done)      state_d = ST_DONE;
                    else if (!bus.count) state_d = ST_STOPPED;
                end
                ST_DONE:    state_d = ST_DONE;
                default:    state_d = ST_STOPPED;
            endcase
        end
    end

    // FSM outputs: done decodes straight from the state register
    always_comb begin
        bus.done = (state_q == ST_DONE);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Datapath next state: clear > load > tick; prescaler only advances in RUNNING
    always_comb begin
        s0_d       = s0_q;
        s1_d       = s1_q;
        min_d      = min_q;
        presc_d    = presc_q;
        sec_tick_d = 1'b0;
        if (bus.clear) begin
            s0_d    = 4'd0;
            s1_d    = 4'd0;
            min_d   = '0;
            presc_d = '0;
        end else if (bus.load) begin
            s0_d    = clamp_nibble(bus.load_value[3:0], 4'd9);
            s1_d    = clamp_nibble(bus.load_value[7:4], 4'd5);
            for (int i = 0; i < MIN_DIGITS; i++) begin
                min_d[i] = clamp_nibble(bus.load_value[8+4*i +: 4], 4'd9);
            end
            presc_d = '0;
        end else if (state_q == ST_RUNNING) begin
            if (tick) begin
                presc_d    = '0;
                sec_tick_d = 1'b1;
                if (!at_limit) begin
                    if (bus.dir) begin
                        s0_d  = dec_s0;
                        s1_d  = dec_s1;
                        min_d = dec_min;
                    end else begin
                        s0_d  = inc_s0;
                        s1_d  = inc_s1;
                        min_d = inc_min;
                    end
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q    <= '0;
            s0_q       <= 4'd0;
            s1_q       <= 4'd0;
            min_q      <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            min_q      <= min_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    assign bus.seconds0 = s0_q;
    assign bus.seconds1 = s1_q;
    assign bus.minutes  = min_q;
    assign bus.sec_tick = sec_tick_q;

`ifdef TIMER_LAP_EN
    // ------------------------------------------------------------------
    // Lap capture: snapshot of the currently displayed (pre-tick) value
    // ------------------------------------------------------------------
    logic [3:0] lap_s0_q, lap_s0_d;
    logic [3:0] lap_s1_q, lap_s1_d;
    min_t       lap_min_q, lap_min_d;
    logic       lap_valid_q, lap_valid_d;

    // Lap next state: clear wipes the snapshot, load leaves it alone
    always_comb begin
        lap_s0_d    = lap_s0_q;
        lap_s1_d    = lap_s1_q;
        lap_min_d   = lap_min_q;
        lap_valid_d = lap_valid_q;
        if (bus.clear) begin
            lap_s0_d    = 4'd0;
            lap_s1_d    = 4'd0;
            lap_min_d   = '0;
            lap_valid_d = 1'b0;
        end else if (bus.lap) begin
            lap_s0_d    = s0_q;
            lap_s1_d    = s1_q;
            lap_min_d   = min_q;
            lap_valid_d = 1'b1;
        end
    end

    // Lap registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_s0_q    <= 4'd0;
            lap_s1_q    <= 4'd0;
            lap_min_q   <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            lap_s0_q    <= lap_s0_d;
            lap_s1_q    <= lap_s1_d;
            lap_min_q   <= lap_min_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    assign bus.lap_seconds0 = lap_s0_q;
    assign bus.lap_seconds1 = lap_s1_q;
    assign bus.lap_minutes  = lap_min_q;
    assign bus.lap_valid    = lap_valid_q;
`endif

endmodule

// File: tb/tb_music_timer_bcd.sv
// Directed bench for music_timer_bcd with TICKS_PER_SEC=4, MIN_DIGITS=2.
// Inputs change and outputs are sampled on the falling clock edge.
// Displayed time is compared as 16-bit BCD {mm, s1, s0}.
module tb_music_timer_bcd;

    localparam int TPS = 4;
    localparam int MD  = 2;

    logic clk = 1'b0;
    logic reset;

    music_timer_bcd_if #(.MIN_DIGITS(MD)) bus ();

    music_timer_bcd #(
        .TICKS_PER_SEC (TPS),
        .MIN_DIGITS    (MD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] shown();
        return {16'h0, bus.minutes, bus.seconds1, bus.seconds0};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_load(input logic [15:0] v);
        bus.load_value = v;
        bus.load       = 1'b1;
        cyc(1);
        bus.load       = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
    endtask

    // Watchdog: the directed sequence is a few hundred cycles long
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int last;
        int bad_gaps;

        bus.count      = 1'b0;
        bus.clear      = 1'b0;
        bus.dir        = 1'b0;
        bus.load       = 1'b0;
        bus.load_value = '0;
`ifdef TIMER_LAP_EN
        bus.lap        = 1'b0;
`endif
        reset = 1'b0;
        cyc(3);
        check("reset_value", shown(), 32'h0000);
        check("reset_tick", {31'h0, bus.sec_tick}, 32'h0);
        check("reset_done", {31'h0, bus.done}, 32'h0);

        // --- 1: up-count from zero for 244 running cycles ---
        reset = 1'b1;
        cyc(1);
        bus.count = 1'b1;
        cyc(1);                       // STOPPED -> RUNNING, prescaler still 0
        pulses   = 0;
        last     = -1;
        bad_gaps = 0;
        for (int i = 1; i <= 244; i++) begin
            cyc(1);
            if (bus.sec_tick) begin
                pulses++;
                if (last >= 0 && (i - last) != 4) bad_gaps++;
                last = i;
            end
            if (i == 60) check("up_mid_0015", shown(), 32'h0015);
        end
        check("up_pulses", pulses, 61);
        check("up_gaps", bad_gaps, 0);
        check("up_0101", shown(), 32'h0101);
        check("up_done", {31'h0, bus.done}, 32'h0);

        // --- 2: up-count into the limit ---
        bus.dir = 1'b0;
        pulse_load(16'h9957);
        check("ld_9957", shown(), 32'h9957);
        cyc(4);
        check("lim_9958", shown(), 32'h9958);
        check("lim_9958_tick", {31'h0, bus.sec_tick}, 32'h1);
        cyc(4);
        check("lim_9959", shown(), 32'h9959);
        check("lim_done", {31'h0, bus.done}, 32'h1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (i == 10) bus.dir = 1'b1;   // dir change in DONE must not matter
            if (bus.sec_tick) pulses++;
        end
        check("lim_no_ticks", pulses, 0);
        check("lim_hold", shown(), 32'h9959);
        check("lim_done_hold", {31'h0, bus.done}, 32'h1);

        // --- 3: down-count to zero, clear, zero-start down run ---
        bus.dir = 1'b1;
        pulse_load(16'h0002);
        check("dn_load", shown(), 32'h0002);
        check("dn_load_done", {31'h0, bus.done}, 32'h0);
        cyc(4);
        check("dn_0001", shown(), 32'h0001);
        cyc(4);
        check("dn_0000", shown(), 32'h0000);
        check("dn_done", {31'h0, bus.done}, 32'h1);
        pulse_clear();
        check("clr_value", shown(), 32'h0000);
        check("clr_done", {31'h0, bus.done}, 32'h0);
        cyc(3);
        check("zero_run_pre", {31'h0, bus.done}, 32'h0);
        cyc(1);
        check("zero_run_done", {31'h0, bus.done}, 32'h1);
        check("zero_run_hold", shown(), 32'h0000);

        // Borrow across the minute boundary
        pulse_load(16'h1000);
        cyc(4);
        check("dn_borrow", shown(), 32'h0959);

        // --- 4: pause keeps the partial second ---
        bus.dir = 1'b0;
        pulse_clear();
        cyc(6);
        check("pause_pre", shown(), 32'h0001);
        bus.count = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (bus.sec_tick) pulses++;
        end
        check("pause_ticks", pulses, 0);
        check("pause_hold", shown(), 32'h0001);
        bus.count = 1'b1;
        cyc(1);
        check("resume_c1_tick", {31'h0, bus.sec_tick}, 32'h0);
        check("resume_c1_val", shown(), 32'h0001);
        cyc(1);
        check("resume_c2_tick", {31'h0, bus.sec_tick}, 32'h1);
        check("resume_c2_val", shown(), 32'h0002);

        // --- 5: clamped load, then clear beats load ---
        bus.count = 1'b0;
        pulse_load(16'h3AF7);
        check("clamp_3957", shown(), 32'h3957);
        cyc(8);
        check("clamp_stopped", shown(), 32'h3957);
        bus.load_value = 16'h1234;
        bus.load       = 1'b1;
        bus.clear      = 1'b1;
        cyc(1);
        bus.load       = 1'b0;
        bus.clear      = 1'b0;
        check("clr_over_load", shown(), 32'h0000);

`ifdef TIMER_LAP_EN
        // --- 6: lap capture ---
        bus.dir   = 1'b0;
        bus.count = 1'b1;
        pulse_clear();
        cyc(20);
        check("lap_main_0005", shown(), 32'h0005);
        bus.lap = 1'b1;
        cyc(1);
        bus.lap = 1'b0;
        cyc(3);
        check("lap_main_0006", shown(), 32'h0006);
        check("lap_value", {16'h0, bus.lap_minutes, bus.lap_seconds1, bus.lap_seconds0}, 32'h0005);
        check("lap_valid", {31'h0, bus.lap_valid}, 32'h1);
        pulse_clear();
        check("lap_clr_value", {16'h0, bus.lap_minutes, bus.lap_seconds1, bus.lap_seconds0}, 32'h0000);
        check("lap_clr_valid", {31'h0, bus.lap_valid}, 32'h0);
        check("lap_clr_main", shown(), 32'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
